// File: rtl/booth_aq_shift_reg.sv
// Combined {A,Q,q_m1} shift register and step counter for the Booth multiplier datapath.
// Define BOOTH_RADIX4_EN for radix-4 stepping (2-bit shifts, WIDTH/2 steps; WIDTH must be even).
module booth_aq_shift_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 ld,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 a_wr,
  input  logic [WIDTH-1:0]     a_in,
  input  logic                 shift,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     q_out,
  output logic                 q_m1,
  output logic [2:0]           q_bits,
  output logic [2*WIDTH-1:0]   p_out,
  output logic [CNT_W-1:0]     count,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned RW = 2 * WIDTH + 1;
`ifdef BOOTH_RADIX4_EN
  localparam int unsigned SH    = 2;
  localparam int unsigned STEPS = WIDTH / 2;
`else
  localparam int unsigned SH    = 1;
  localparam int unsigned STEPS = WIDTH;
`endif

  logic [RW-1:0]    r, r_nxt, r_src;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done_nxt, err_nxt;

  // Next-state: clr > ld > {a_wr, shift}; ALU write-back feeds the shifter on the same edge
  always_comb begin
    r_nxt    = r;
    cnt_nxt  = cnt;
    done_nxt = done;
    err_nxt  = err;
    r_src    = {(a_wr ? a_in : r[RW-1:WIDTH+1]), r[WIDTH:0]};
    if (clr) begin
      r_nxt    = '0;
      cnt_nxt  = '0;
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
    end else if (ld) begin
      r_nxt    = {WIDTH'(0), q_in, 1'b0};
      cnt_nxt  = CNT_W'(STEPS);
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
    end else if (shift) begin
      if (cnt == '0) begin
        r_nxt   = r_src;
        err_nxt = 1'b1;
      end else begin
        r_nxt   = RW'($signed(r_src) >>> SH);
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) done_nxt = 1'b1;
      end
    end else begin
      r_nxt = r_src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r    <= '0;
      cnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      r    <= r_nxt;
      cnt  <= cnt_nxt;
      done <= done_nxt;
      err  <= err_nxt;
    end
  end

  // Output decodes of the state register
  assign a_out  = r[RW-1:WIDTH+1];
  assign q_out  = r[WIDTH:1];
  assign q_m1   = r[0];
  assign q_bits = r[2:0];
  assign p_out  = r[RW-1:1];
  assign count  = cnt;

endmodule

// File: tb/tb_booth_aq_shift_reg.sv
// Randomized self-checking bench for booth_aq_shift_reg against an arithmetic reference model.
module tb_booth_aq_shift_reg;
  localparam int unsigned W     = 16;
  localparam int unsigned CW    = $clog2(W + 1);
`ifdef BOOTH_RADIX4_EN
  localparam int unsigned SH    = 2;
  localparam int unsigned STEPS = W / 2;
`else
  localparam int unsigned SH    = 1;
  localparam int unsigned STEPS = W;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, ld = 1'b0, a_wr = 1'b0, shift = 1'b0;
  logic [W-1:0] q_in = '0, a_in = '0;
  logic [W-1:0] a_out, q_out;
  logic q_m1, done, err;
  logic [2:0] q_bits;
  logic [2*W-1:0] p_out;
  logic [CW-1:0] count;

  booth_aq_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .q_in(q_in), .a_wr(a_wr),
    .a_in(a_in), .shift(shift), .a_out(a_out), .q_out(q_out), .q_m1(q_m1),
    .q_bits(q_bits), .p_out(p_out), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [W-1:0] ma, mq;
  logic mqm1, mdone, merr;
  int mcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ma = '0; mq = '0; mqm1 = 1'b0; mcnt = 0; mdone = 1'b0; merr = 1'b0;
  endtask

  // Booth step as a floor division of the signed {A,Q,q_m1} value by 2**SH
  task automatic model_update(input logic c, input logic l, input logic [W-1:0] qi,
                              input logic aw, input logic [W-1:0] ai, input logic s);
    logic [W-1:0] a;
    logic [2*W:0] bits;
    longint v, d, qt;
    if (c) model_reset();
    else if (l) begin
      ma = '0; mq = qi; mqm1 = 1'b0; mcnt = STEPS; mdone = 1'b0; merr = 1'b0;
    end else begin
      a = aw ? ai : ma;
      if (s && mcnt == 0) begin
        ma = a; merr = 1'b1;
      end else if (s) begin
        v  = longint'($signed({a, mq, mqm1}));
        d  = longint'(1) << SH;
        qt = v / d;
        if ((v % d) != 0 && v < 0) qt = qt - 1;
        bits = qt[2*W:0];
        ma = bits[2*W:W+1]; mq = bits[W:1]; mqm1 = bits[0];
        mcnt = mcnt - 1;
        if (mcnt == 0) mdone = 1'b1;
      end else begin
        ma = a;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"}, 64'(a_out), 64'(ma));
    check({tag, ".q"}, 64'(q_out), 64'(mq));
    check({tag, ".qm1"}, 64'(q_m1), 64'(mqm1));
    check({tag, ".qbits"}, 64'(q_bits), 64'({mq[1], mq[0], mqm1}));
    check({tag, ".p"}, 64'(p_out), 64'({ma, mq}));
    check({tag, ".cnt"}, 64'(count), 64'(mcnt));
    check({tag, ".done"}, 64'(done), 64'(mdone));
    check({tag, ".err"}, 64'(err), 64'(merr));
  endtask

  task automatic step(input string tag, input logic c, input logic l, input logic [W-1:0] qi,
                      input logic aw, input logic [W-1:0] ai, input logic s);
    @(negedge clk);
    clr = c; ld = l; q_in = qi; a_wr = aw; a_in = ai; shift = s;
    @(posedge clk);
    model_update(c, l, qi, aw, ai, s);
    #1;
    check_all(tag);
    clr = 1'b0; ld = 1'b0; a_wr = 1'b0; shift = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all("reset0");
    @(negedge clk);
    rst_n = 1'b1;

    // Load
    step("load", 0, 1, 16'hB5A3, 0, '0, 0);
    check("load.q_const", 64'(q_out), 64'h B5A3);
    check("load.cnt_const", 64'(count), 64'(STEPS));

    // Merged ALU write-back and shift
    step("mload", 0, 1, 16'h0003, 0, '0, 0);
    step("merge", 0, 0, '0, 1, 16'h8001, 1);
`ifdef BOOTH_RADIX4_EN
    check("merge.a_const", 64'(a_out), 64'hE000);
    check("merge.q_const", 64'(q_out), 64'h4000);
`else
    check("merge.a_const", 64'(a_out), 64'hC000);
    check("merge.q_const", 64'(q_out), 64'h8001);
`endif
    check("merge.qm1_const", 64'(q_m1), 64'd1);
    check("merge.cnt_const", 64'(count), 64'(STEPS - 1));

    // Completion, over-shift and recovery
    step("cload", 0, 1, W'($urandom), 0, '0, 0);
    for (int i = 0; i < int'(STEPS); i++) begin
      check("pre_done", 64'(done), 64'd0);
      step("cshift", 0, 0, '0, 0, '0, 1);
    end
    check("done_const", 64'(done), 64'd1);
    check("done_cnt_const", 64'(count), 64'd0);
    step("over", 0, 0, '0, 0, '0, 1);
    check("over_err_const", 64'(err), 64'd1);
    step("over_aw", 0, 0, '0, 1, W'($urandom), 1);
    step("reload", 0, 1, W'($urandom), 0, '0, 0);
    check("reload_err_const", 64'(err), 64'd0);

    // Clear beats a simultaneous write-back and shift
    while (mcnt > 9) step("pre_clr", 0, 0, '0, $urandom_range(0, 1), W'($urandom), 1);
    step("clr", 1, 0, '0, 1, 16'h1234, 1);
    check("clr_cnt_const", 64'(count), 64'd0);
    step("clr_shift", 0, 0, '0, 0, '0, 1);
    check("clr_err_const", 64'(err), 64'd1);

    // Asynchronous reset mid-step
    step("rload", 0, 1, 16'hFFFF, 0, '0, 0);
    step("rstep", 0, 0, '0, 1, 16'h9ABC, 1);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned pick;
      pick = $urandom_range(0, 99);
      step("rand", pick < 3, (pick >= 3 && pick < 12), W'($urandom),
           1'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
